// File: rtl/addr_burst_gen_if.sv
// Handshake bundle between the offset shifter, addr_burst_gen and the data router.
// err_misalign is present only when ADDR_ALIGN_CHK_EN is defined.
interface addr_burst_gen_if #(
  parameter int ADDR_W = 32,
  parameter int LEN_W  = 4
);
  logic              in_valid;
  logic              in_ready;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W-1:0] byte_off;
  logic [LEN_W-1:0]  burst_len;
  logic              out_valid;
  logic              out_ready;
  logic [ADDR_W-1:0] out_addr;
  logic              out_last;
  logic              busy;
`ifdef ADDR_ALIGN_CHK_EN
  logic              err_misalign;
`endif

  modport slave (
    input  in_valid, base_addr, byte_off, burst_len, out_ready,
    output in_ready, out_valid, out_addr, out_last,
`ifdef ADDR_ALIGN_CHK_EN
    output err_misalign,
`endif
    output busy
  );

  modport master (
    output in_valid, base_addr, byte_off, burst_len, out_ready,
    input  in_ready, out_valid, out_addr, out_last,
`ifdef ADDR_ALIGN_CHK_EN
    input  err_misalign,
`endif
    input  busy
  );
endinterface

// File: rtl/addr_burst_gen.sv
// Expands one (base + offset, length) request into a burst of word-stride byte addresses.
// Optional ADDR_ALIGN_CHK_EN rejects misaligned start addresses with a one-cycle err_misalign pulse.
//
// state   | meaning
// S_IDLE  | waiting for a request, in_ready=1
// S_BURST | presenting beats, out_valid=1
module addr_burst_gen #(
  parameter int ADDR_W = 32,
  parameter int LEN_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  addr_burst_gen_if.slave   bus
);

  typedef enum logic {S_IDLE = 1'b0, S_BURST = 1'b1} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  rem_q, rem_d;
  logic              last_q, last_d;
  logic [ADDR_W-1:0] start_addr;
  logic              misalign;
`ifdef ADDR_ALIGN_CHK_EN
  logic              err_q, err_d;
`endif

  assign start_addr = bus.base_addr + bus.byte_off;

`ifdef ADDR_ALIGN_CHK_EN
  assign misalign = (start_addr[1:0] != 2'b00);
`else
  assign misalign = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      last_q  <= 1'b0;
`ifdef ADDR_ALIGN_CHK_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      last_q  <= last_d;
`ifdef ADDR_ALIGN_CHK_EN
      err_q   <= err_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    last_d  = last_q;
`ifdef ADDR_ALIGN_CHK_EN
    err_d   = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          if (misalign) begin
`ifdef ADDR_ALIGN_CHK_EN
            err_d = 1'b1;
`endif
          end else begin
            addr_d  = start_addr;
            rem_d   = bus.burst_len;
            last_d  = (bus.burst_len == '0);
            state_d = S_BURST;
          end
        end
      end
      S_BURST: begin
        if (bus.out_ready) begin
          if (rem_q != '0) begin
            addr_d = addr_q + ADDR_W'(4);
            rem_d  = rem_q - LEN_W'(1);
            // the beat being advanced to is final when one beat was left after this one
            last_d = (rem_q == LEN_W'(1));
          end else begin
            state_d = S_IDLE;
            last_d  = 1'b0;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.out_valid = (state_q == S_BURST);
  assign bus.busy      = (state_q == S_BURST);
  assign bus.out_addr  = addr_q;
  assign bus.out_last  = last_q;
`ifdef ADDR_ALIGN_CHK_EN
  assign bus.err_misalign = err_q;
`endif

endmodule

// File: tb/tb_addr_burst_gen.sv
// Directed bench for addr_burst_gen: vector table of bursts plus hand sequences for reset, overlap and idle cases.
module tb_addr_burst_gen;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  addr_burst_gen_if #(.ADDR_W(32), .LEN_W(4)) bus ();

  addr_burst_gen #(.ADDR_W(32), .LEN_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] base;
    logic [31:0] off;
    logic [3:0]  len;
    logic [31:0] exp_first;
    logic [31:0] exp_last;
    int          beats;
    int          stall_beat;
    int          stall_cycles;
  } vec_t;

  vec_t vecs[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    string tag;
    logic [31:0] exp_addr;
    tag = $sformatf("vec%0d", idx);
    bus.base_addr = v.base;
    bus.byte_off  = v.off;
    bus.burst_len = v.len;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b0;
    chk({tag, ".in_ready_pre"}, {31'd0, bus.in_ready}, 32'd1);
    tick();
    bus.in_valid  = 1'b0;
    bus.base_addr = '0;
    bus.byte_off  = '0;
    for (int i = 0; i < v.beats; i++) begin
      exp_addr = v.exp_first + 32'(4 * i);
      if (i == v.stall_beat) begin
        for (int s = 0; s < v.stall_cycles; s++) begin
          chk($sformatf("%s.stall_valid%0d", tag, s), {31'd0, bus.out_valid}, 32'd1);
          chk($sformatf("%s.stall_addr%0d", tag, s), bus.out_addr, exp_addr);
          tick();
        end
      end
      bus.out_ready = 1'b1;
      chk($sformatf("%s.valid%0d", tag, i), {31'd0, bus.out_valid}, 32'd1);
      chk($sformatf("%s.busy%0d", tag, i), {31'd0, bus.busy}, 32'd1);
      chk($sformatf("%s.in_ready%0d", tag, i), {31'd0, bus.in_ready}, 32'd0);
      chk($sformatf("%s.addr%0d", tag, i), bus.out_addr, exp_addr);
      chk($sformatf("%s.last%0d", tag, i), {31'd0, bus.out_last}, (i == v.beats - 1) ? 32'd1 : 32'd0);
      if (i == v.beats - 1) chk({tag, ".last_addr"}, bus.out_addr, v.exp_last);
      tick();
      bus.out_ready = 1'b0;
    end
    chk({tag, ".valid_after"}, {31'd0, bus.out_valid}, 32'd0);
    chk({tag, ".in_ready_after"}, {31'd0, bus.in_ready}, 32'd1);
    chk({tag, ".busy_after"}, {31'd0, bus.busy}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    checks   = 0;
    failures = 0;
    vecs.push_back('{32'h0000_2000, 32'h8,  4'd0,  32'h0000_2008, 32'h0000_2008, 1,  -1, 0});
    vecs.push_back('{32'h0000_0100, 32'h0,  4'd3,  32'h0000_0100, 32'h0000_010C, 4,  1,  3});
    vecs.push_back('{32'hFFFF_FFF8, 32'h4,  4'd2,  32'hFFFF_FFFC, 32'h0000_0004, 3,  -1, 0});
    vecs.push_back('{32'h0000_0040, 32'h20, 4'd15, 32'h0000_0060, 32'h0000_009C, 16, 15, 2});
`ifndef ADDR_ALIGN_CHK_EN
    vecs.push_back('{32'h0000_1001, 32'h4,  4'd1,  32'h0000_1005, 32'h0000_1009, 2,  -1, 0});
`endif

    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.base_addr = '0;
    bus.byte_off  = '0;
    bus.burst_len = '0;
    bus.out_ready = 1'b0;
    tick();
    tick();
    chk("rst.in_ready",  {31'd0, bus.in_ready},  32'd1);
    chk("rst.out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst.out_addr",  bus.out_addr,           32'd0);
    chk("rst.out_last",  {31'd0, bus.out_last},  32'd0);
    chk("rst.busy",      {31'd0, bus.busy},      32'd0);
`ifdef ADDR_ALIGN_CHK_EN
    chk("rst.err", {31'd0, bus.err_misalign}, 32'd0);
`endif
    #3 rst_n = 1'b1;
    tick();

    foreach (vecs[k]) run_vec(vecs[k], k);

    // reset asserted between clock edges in the middle of a burst
    bus.base_addr = 32'h1000;
    bus.byte_off  = 32'h10;
    bus.burst_len = 4'd3;
    bus.in_valid  = 1'b1;
    tick();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    chk("mid.beat0", bus.out_addr, 32'h1010);
    tick();
    bus.out_ready = 1'b0;
    chk("mid.beat1", bus.out_addr, 32'h1014);
    #1 rst_n = 1'b0;
    #1;
    chk("mid.rst_valid",    {31'd0, bus.out_valid}, 32'd0);
    chk("mid.rst_addr",     bus.out_addr,           32'd0);
    chk("mid.rst_last",     {31'd0, bus.out_last},  32'd0);
    chk("mid.rst_busy",     {31'd0, bus.busy},      32'd0);
    chk("mid.rst_in_ready", {31'd0, bus.in_ready},  32'd1);
    tick();
    #2 rst_n = 1'b1;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk($sformatf("mid.no_beat%0d", c), {31'd0, bus.out_valid}, 32'd0);
      chk($sformatf("mid.ready%0d", c), {31'd0, bus.in_ready}, 32'd1);
    end
    bus.out_ready = 1'b0;

    // request during burst is ignored; next request accepted after one idle cycle
    bus.base_addr = 32'h300;
    bus.byte_off  = 32'h0;
    bus.burst_len = 4'd2;
    bus.in_valid  = 1'b1;
    tick();
    bus.base_addr = 32'h5000;
    bus.burst_len = 4'd7;
    chk("ovl.in_ready_busy", {31'd0, bus.in_ready}, 32'd0);
    tick();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("ovl.addr%0d", i), bus.out_addr, 32'h300 + 32'(4 * i));
      chk($sformatf("ovl.last%0d", i), {31'd0, bus.out_last}, (i == 2) ? 32'd1 : 32'd0);
      tick();
    end
    chk("ovl.gap_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("ovl.gap_ready", {31'd0, bus.in_ready},  32'd1);
    bus.base_addr = 32'h600;
    bus.burst_len = 4'd0;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b0;
    tick();
    bus.in_valid  = 1'b0;
    chk("ovl.second_valid", {31'd0, bus.out_valid}, 32'd1);
    chk("ovl.second_addr",  bus.out_addr,           32'h600);
    chk("ovl.second_last",  {31'd0, bus.out_last},  32'd1);
    bus.out_ready = 1'b1;
    tick();

    // out_ready in idle has no effect; out_addr keeps the final beat
    for (int c = 0; c < 2; c++) begin
      chk($sformatf("idle.valid%0d", c), {31'd0, bus.out_valid}, 32'd0);
      chk($sformatf("idle.addr%0d", c),  bus.out_addr,           32'h600);
      tick();
    end
    bus.out_ready = 1'b0;

`ifdef ADDR_ALIGN_CHK_EN
    bus.base_addr = 32'h1001;
    bus.byte_off  = 32'h4;
    bus.burst_len = 4'd1;
    bus.in_valid  = 1'b1;
    chk("mis.err_pre", {31'd0, bus.err_misalign}, 32'd0);
    tick();
    bus.in_valid  = 1'b0;
    chk("mis.err_pulse", {31'd0, bus.err_misalign}, 32'd1);
    chk("mis.valid0",    {31'd0, bus.out_valid},    32'd0);
    chk("mis.ready0",    {31'd0, bus.in_ready},     32'd1);
    tick();
    chk("mis.err_drop",  {31'd0, bus.err_misalign}, 32'd0);
    chk("mis.valid1",    {31'd0, bus.out_valid},    32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/addr_burst_gen.md
Name: addr_burst_gen

Overview:
- Stage directly downstream of the 2-bit word-to-byte offset shifter in the address-calculation path.
- Accepts a base address, the shifter's byte offset and a burst length over a valid/ready handshake.
- Emits a burst of consecutive word-aligned byte addresses (stride 4) to the data router over a second valid/ready handshake.
- Two-state FSM with a beat counter; one request in flight at a time.

Parameters:
- ADDR_W, 32, address / offset width in bits.
- LEN_W, 4, burst-length field width; a burst carries burst_len+1 beats (1..2^LEN_W).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  request present.
- in_ready  output  1  block can accept a request.
- base_addr  input  ADDR_W  base byte address.
- byte_off  input  ADDR_W  byte offset from shifter (index<<2).
- burst_len  input  LEN_W  beats minus one.
- out_valid  output  1  out_addr valid.
- out_ready  input  1  consumer accepts beat.
- out_addr  output  ADDR_W  current beat byte address.
- out_last  output  1  current beat is final beat of burst.
- busy  output  1  burst in progress.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_n. Assertion forces all state to reset immediately, including mid-burst. No partial burst resumes after reset release.
- Reset values: state=IDLE, out_valid=0, out_addr=0, out_last=0, busy=0, in_ready=1. Internal remaining counter = 0.
- States: IDLE and BURST.
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid&&in_ready at a rising edge:
    - out_addr <= base_addr + byte_off, truncated mod 2^ADDR_W with no carry out.
    - remaining <= burst_len.
    - state <= BURST.
  - First beat is presented the cycle after acceptance (latency 1).
- BURST:
  - in_ready=0, out_valid=1, busy=1, out_last=(remaining==0).
  - out_addr, out_last and remaining hold stable while out_valid&&!out_ready.
  - On out_valid&&out_ready with remaining!=0: out_addr <= out_addr+4, wrapping mod 2^ADDR_W; remaining <= remaining-1.
  - On out_valid&&out_ready with remaining==0: state <= IDLE, out_valid <= 0, out_last <= 0. out_addr holds its last value.
  - in_ready returns to 1 in the cycle after the last beat. There is no same-cycle re-accept, so the minimum gap between bursts is one idle cycle.
- Boundary conditions:
  - burst_len=0 gives a single beat with out_last=1 on that beat.
  - burst_len=all ones gives 2^LEN_W beats.
  - Address wrap-around: 0xFFFFFFFC+4 = 0x00000000, with no flag.
  - in_valid asserted during BURST is ignored (in_ready=0); the inputs need not be held.
  - out_ready asserted in IDLE has no effect.
- All outputs are registered except in_ready, which is decoded directly from state.

Optional Feature:
- Macro: ADDR_ALIGN_CHK_EN.
- Defined:
  - Adds output port err_misalign (1 bit, reset 0).
  - If at acceptance (base_addr+byte_off)[1:0]!=0, the request is consumed with no burst; state stays IDLE.
  - err_misalign pulses 1 for exactly one cycle, the cycle after acceptance.
  - Aligned requests behave exactly as in the base behaviour.
- Not defined:
  - No err_misalign port.
  - Misaligned sums are used unmodified; subsequent beats keep the same low two bits.

Test Plan:
- Reset mid-burst: base=0x1000, off=0x10, len=3; drop rst_n after beat 1 -> all outputs at reset values asynchronously; after release in_ready=1, no further beats.
- Single beat: base=0x2000, off=0x8, len=0, out_ready=1 -> one cycle later out_addr=0x2008, out_valid=1, out_last=1; next cycle out_valid=0, in_ready=1.
- Four-beat burst with backpressure: base=0x100, off=0x0, len=3, out_ready low on the 2nd beat for 3 cycles -> addresses 0x100, 0x104, 0x108, 0x10C; 0x104 is held stable for 3 cycles; out_last=1 only on 0x10C.
- Wrap-around: base=0xFFFFFFF8, off=0x4, len=2 -> 0xFFFFFFFC, 0x00000000, 0x00000004.
- Request during burst: second in_valid pulse during BURST -> ignored, in_ready=0; after burst completes, a new request is accepted with one idle cycle between bursts.
- Misalign with ADDR_ALIGN_CHK_EN defined: base=0x1001, off=0x4, len=1 -> err_misalign=1 for one cycle, out_valid stays 0.
- Misalign without the macro: same stimulus -> 0x1005, 0x1009 emitted.
